// File: rtl/synth_pkg.sv
// Shared synth definitions: SPI framing constants, register-number scope fields
// and the SPI front-end state type.
package synth_pkg;

    localparam int SPI_BYTE_BITS   = 8;
    localparam int SPI_COUNT_BITS  = $clog2(SPI_BYTE_BITS);
    localparam int REG_NUMBER_BITS = 16;

    // Register-number scope field (bits [15:14]) as decoded by the synth core.
    localparam logic [1:0] SCOPE_VOICE_OP = 2'b11;
    localparam logic [1:0] SCOPE_VOICE    = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA
    } SpiState_t;

    typedef logic [SPI_BYTE_BITS-1:0]   spi_byte_t;
    typedef logic [REG_NUMBER_BITS-1:0] reg_number_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchronizer for a single asynchronous input bit; all stages
// clear to 0 on reset.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            // NOTE: non-blocking, so every stage takes its neighbour's previous value.
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/spi_register_writer.sv
// SPI mode-0 slave that frames host bytes into 16-bit register-number / 8-bit value
// write strobes with burst auto-increment, plus a MISO echo of the previous byte.
module spi_register_writer
    import synth_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset_n,
    input  logic                       i_SpiClock,
    input  logic                       i_SpiMosi,
    input  logic                       i_SpiChipSelect_n,
    output logic                       o_SpiMiso,
    output logic                       o_RegisterWriteEnable,
    output logic [REG_NUMBER_BITS-1:0] o_RegisterNumber,
    output logic [SPI_BYTE_BITS-1:0]   o_RegisterValue,
    output logic                       o_FrameError
);

    logic sck_s, mosi_s, cs_n_s;

    sync_ff #(.N(SYNC_STAGES)) u_sync_sck (
        .clk(i_Clock), .rst_n(i_Reset_n), .d(i_SpiClock), .q(sck_s)
    );
    sync_ff #(.N(SYNC_STAGES)) u_sync_mosi (
        .clk(i_Clock), .rst_n(i_Reset_n), .d(i_SpiMosi), .q(mosi_s)
    );
    sync_ff #(.N(SYNC_STAGES)) u_sync_cs (
        .clk(i_Clock), .rst_n(i_Reset_n), .d(i_SpiChipSelect_n), .q(cs_n_s)
    );

    // Edge detection. CS_n history resets low so a CS_n held low across reset
    // release never looks like a frame start.
    logic sck_d, cs_n_d;
    logic sck_rise_q, cs_rise_q, cs_fall_q, mosi_q;
    logic sck_fall;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sck_d      <= 1'b0;
            cs_n_d     <= 1'b0;
            sck_rise_q <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            sck_d      <= sck_s;
            cs_n_d     <= cs_n_s;
            sck_rise_q <= sck_s & ~sck_d;
            cs_rise_q  <= cs_n_s & ~cs_n_d;
            cs_fall_q  <= ~cs_n_s & cs_n_d;
            mosi_q     <= mosi_s;
        end
    end

    assign sck_fall = sck_d & ~sck_s;

    // Bit level: shift register, bit counter, MISO echo and frame-error detection.
    logic                      active;
    logic [SPI_COUNT_BITS-1:0] bit_count, count_next;
    spi_byte_t                 shift_reg, echo_reg;
    logic                      byte_done, frame_start, frame_end;

    assign count_next = (active && sck_rise_q) ? bit_count + 1'b1 : bit_count;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            active       <= 1'b0;
            bit_count    <= '0;
            shift_reg    <= '0;
            echo_reg     <= '0;
            byte_done    <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            o_SpiMiso    <= 1'b0;
            o_FrameError <= 1'b0;
        end else begin
            byte_done    <= 1'b0;
            o_FrameError <= 1'b0;
            frame_start  <= cs_fall_q;
            frame_end    <= cs_rise_q;
            if (cs_fall_q) begin
                active    <= 1'b1;
                bit_count <= '0;
                echo_reg  <= '0;
                o_SpiMiso <= 1'b0;
            end else begin
                if (active && sck_rise_q) begin
                    shift_reg <= {shift_reg[SPI_BYTE_BITS-2:0], mosi_q};
                    bit_count <= count_next;
                    if (bit_count == SPI_COUNT_BITS'(SPI_BYTE_BITS - 1)) begin
                        byte_done <= 1'b1;
                        echo_reg  <= {shift_reg[SPI_BYTE_BITS-2:0], mosi_q};
                    end
                end
                if (active && sck_fall) begin
                    o_SpiMiso <= echo_reg[SPI_BYTE_BITS-1];
                    echo_reg  <= {echo_reg[SPI_BYTE_BITS-2:0], 1'b0};
                end
                // A bit completing on the same cycle as CS_n rise still counts.
                if (cs_rise_q) begin
                    active       <= 1'b0;
                    bit_count    <= '0;
                    o_SpiMiso    <= 1'b0;
                    o_FrameError <= active && (count_next != '0);
                end
            end
        end
    end

    // Byte level: frame FSM with auto-incrementing register number.
    SpiState_t   state;
    spi_byte_t   addr_hi;
    reg_number_t next_number;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state                 <= IDLE;
            addr_hi               <= '0;
            next_number           <= '0;
            o_RegisterWriteEnable <= 1'b0;
            o_RegisterNumber      <= '0;
            o_RegisterValue       <= '0;
        end else begin
            o_RegisterWriteEnable <= 1'b0;
            if (byte_done) begin
                case (state)
                    ADDR_HI: begin
                        addr_hi <= shift_reg;
                        state   <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        next_number <= {addr_hi, shift_reg};
                        state       <= DATA;
                    end
                    DATA: begin
                        o_RegisterWriteEnable <= 1'b1;
                        o_RegisterNumber      <= next_number;
                        o_RegisterValue       <= shift_reg;
                        next_number           <= next_number + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (frame_start) state <= ADDR_HI;
            if (frame_end)   state <= IDLE;
        end
    end

endmodule

// File: tb/tb_spi_register_writer.sv
// Self-checking bench for spi_register_writer: table of directed frames, random
// frames against a byte-level reference model, and hand-written timing corners.
module tb_spi_register_writer;

    localparam int SYNC = 2;
    localparam int HALF = 5;

    logic        i_Clock;
    logic        i_Reset_n;
    logic        i_SpiClock;
    logic        i_SpiMosi;
    logic        i_SpiChipSelect_n;
    logic        o_SpiMiso;
    logic        o_RegisterWriteEnable;
    logic [15:0] o_RegisterNumber;
    logic [7:0]  o_RegisterValue;
    logic        o_FrameError;

    spi_register_writer #(.SYNC_STAGES(SYNC)) dut (
        .i_Clock              (i_Clock),
        .i_Reset_n            (i_Reset_n),
        .i_SpiClock           (i_SpiClock),
        .i_SpiMosi            (i_SpiMosi),
        .i_SpiChipSelect_n    (i_SpiChipSelect_n),
        .o_SpiMiso            (o_SpiMiso),
        .o_RegisterWriteEnable(o_RegisterWriteEnable),
        .o_RegisterNumber     (o_RegisterNumber),
        .o_RegisterValue      (o_RegisterValue),
        .o_FrameError         (o_FrameError)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef logic [23:0] wr_t;
    wr_t got_q[$];
    wr_t exp_q[$];
    int  fe_count = 0;

    always @(negedge i_Clock) begin
        if (o_RegisterWriteEnable) got_q.push_back({o_RegisterNumber, o_RegisterValue});
        if (o_FrameError) fe_count++;
    end

    logic [7:0] fb      [16];
    logic [7:0] miso_rx [16];
    logic [7:0] miso_byte;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_Clock);
    endtask

    // Sends the top nbits of b MSB first; MISO is sampled just before each SCK rise.
    task automatic spi_bits(input logic [7:0] b, input int nbits, input bit cs_with_last);
        for (int i = 7; i > 7 - nbits; i--) begin
            i_SpiMosi = b[i];
            wait_clk(HALF);
            miso_byte = {miso_byte[6:0], o_SpiMiso};
            i_SpiClock = 1'b1;
            if (cs_with_last && i == 8 - nbits) i_SpiChipSelect_n = 1'b1;
            wait_clk(HALF);
            i_SpiClock = 1'b0;
        end
    endtask

    task automatic send_frame(input int n, input int tail, input logic [7:0] tail_byte,
                              input bit cs_with_last);
        i_SpiChipSelect_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < n; i++) begin
            spi_bits(fb[i], 8, cs_with_last && i == n - 1 && tail == 0);
            miso_rx[i] = miso_byte;
        end
        if (tail > 0) spi_bits(tail_byte, tail, 1'b0);
        wait_clk(4);
        i_SpiChipSelect_n = 1'b1;
        wait_clk(12);
    endtask

    // Reference: bytes 0/1 form the start number, every later byte writes start+k mod 2^16.
    task automatic model_frame(input int n);
        logic [15:0] num;
        exp_q.delete();
        for (int i = 2; i < n; i++) begin
            num = {fb[0], fb[1]} + 16'(i - 2);
            exp_q.push_back({num, fb[i]});
        end
    endtask

    task automatic run_checked(input string tag, input int n, input int tail, input bit cs_last);
        int  fe0;
        wr_t g;
        got_q.delete();
        fe0 = fe_count;
        send_frame(n, tail, 8'($urandom), cs_last);
        model_frame(n);
        check({tag, " write count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 24'bx;
            check($sformatf("%s write %0d", tag, i), 32'(g), 32'(exp_q[i]));
        end
        check({tag, " frame errors"}, 32'(fe_count - fe0), (tail != 0) ? 32'd1 : 32'd0);
        for (int i = 0; i < n; i++)
            check($sformatf("%s miso byte %0d", tag, i), 32'(miso_rx[i]),
                  (i == 0) ? 32'd0 : 32'(fb[i-1]));
    endtask

    typedef struct {
        logic [7:0]  b [6];
        int          n;
        int          tail;
        int          exp_count;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        logic [7:0]  exp_last_val;
        bit          exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  fe0, k, n, tail;
        bit  seen, cs_last;
        wr_t g;

        i_SpiClock = 1'b0;
        i_SpiMosi = 1'b0;
        i_SpiChipSelect_n = 1'b1;
        i_Reset_n = 1'b0;
        miso_byte = 8'h00;
        wait_clk(3);
        check("reset we",    32'(o_RegisterWriteEnable), 32'd0);
        check("reset num",   32'(o_RegisterNumber),      32'd0);
        check("reset val",   32'(o_RegisterValue),       32'd0);
        check("reset ferr",  32'(o_FrameError),          32'd0);
        check("reset miso",  32'(o_SpiMiso),             32'd0);
        i_Reset_n = 1'b1;
        wait_clk(10);

        vecs[0] = '{'{8'hC0, 8'h05, 8'h7F, 8'h00, 8'h00, 8'h00}, 3, 0, 1, 16'hC005, 16'hC005, 8'h7F, 1'b0};
        vecs[1] = '{'{8'h80, 8'h01, 8'h11, 8'h22, 8'h33, 8'h00}, 5, 0, 3, 16'h8001, 16'h8003, 8'h33, 1'b0};
        vecs[2] = '{'{8'hFF, 8'hFF, 8'hAA, 8'hBB, 8'h00, 8'h00}, 4, 0, 2, 16'hFFFF, 16'h0000, 8'hBB, 1'b0};
        vecs[3] = '{'{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 4, 0, 16'h0000, 16'h0000, 8'h00, 1'b1};
        vecs[4] = '{'{8'hC1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00}, 3, 0, 1, 16'hC100, 16'hC100, 8'h01, 1'b0};
        vecs[5] = '{'{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 0, 0, 16'h0000, 16'h0000, 8'h00, 1'b0};
        vecs[6] = '{'{8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00}, 3, 3, 1, 16'h1234, 16'h1234, 8'h56, 1'b1};

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 6; i++) fb[i] = vecs[v].b[i];
            got_q.delete();
            fe0 = fe_count;
            send_frame(vecs[v].n, vecs[v].tail, 8'h00, 1'b0);
            check($sformatf("vec%0d count", v), 32'(got_q.size()), 32'(vecs[v].exp_count));
            if (vecs[v].exp_count > 0) begin
                g = (got_q.size() > 0) ? got_q[0] : 24'bx;
                check($sformatf("vec%0d first num", v), 32'(g[23:8]), 32'(vecs[v].exp_first));
                g = (got_q.size() > 0) ? got_q[$] : 24'bx;
                check($sformatf("vec%0d last num", v), 32'(g[23:8]), 32'(vecs[v].exp_last));
                check($sformatf("vec%0d last val", v), 32'(g[7:0]), 32'(vecs[v].exp_last_val));
            end
            check($sformatf("vec%0d ferr", v), 32'(fe_count - fe0), 32'(vecs[v].exp_err));
        end

        // MISO echo: zeros during byte 0, then byte 0 during byte 1; idle low afterwards.
        fb[0] = 8'hA5; fb[1] = 8'h3C;
        send_frame(2, 0, 8'h00, 1'b0);
        check("miso byte0", 32'(miso_rx[0]), 32'h00);
        check("miso byte1", 32'(miso_rx[1]), 32'hA5);
        check("miso idle",  32'(o_SpiMiso),  32'd0);

        // CS_n rise coincident with the final SCK rise still issues the write.
        fb[0] = 8'h70; fb[1] = 8'h10; fb[2] = 8'h99;
        run_checked("cs with last", 3, 0, 1'b1);

        // Strobe latency from the SCK rise of the last data bit.
        got_q.delete();
        i_SpiChipSelect_n = 1'b0;
        wait_clk(4);
        spi_bits(8'h55, 8, 1'b0);
        spi_bits(8'h66, 8, 1'b0);
        spi_bits(8'h77, 7, 1'b0);
        i_SpiMosi = 1'b1;
        wait_clk(HALF);
        i_SpiClock = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge i_Clock); #1;
            k++;
            if (o_RegisterWriteEnable) seen = 1'b1;
        end
        check("strobe latency", 32'(k), 32'(SYNC + 3));
        wait_clk(HALF);
        i_SpiClock = 1'b0;
        wait_clk(4);
        i_SpiChipSelect_n = 1'b1;
        wait_clk(12);
        g = (got_q.size() > 0) ? got_q[0] : 24'bx;
        check("latency write", 32'(g), 32'h556677);
        check("latency single strobe", 32'(got_q.size()), 32'd1);

        // Frame-error latency from a mid-byte CS_n rise.
        fe0 = fe_count;
        i_SpiChipSelect_n = 1'b0;
        wait_clk(4);
        spi_bits(8'hAB, 3, 1'b0);
        wait_clk(4);
        i_SpiChipSelect_n = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge i_Clock); #1;
            k++;
            if (o_FrameError) seen = 1'b1;
        end
        check("ferr latency", 32'(k), 32'(SYNC + 2));
        wait_clk(12);
        check("ferr single pulse", 32'(fe_count - fe0), 32'd1);

        // Reset during byte 1 aborts the frame and clears outputs at once.
        got_q.delete();
        fe0 = fe_count;
        i_SpiChipSelect_n = 1'b0;
        wait_clk(4);
        spi_bits(8'hC2, 8, 1'b0);
        spi_bits(8'h03, 3, 1'b0);
        i_Reset_n = 1'b0;
        #1;
        check("midreset we",   32'(o_RegisterWriteEnable), 32'd0);
        check("midreset num",  32'(o_RegisterNumber),      32'd0);
        check("midreset val",  32'(o_RegisterValue),       32'd0);
        check("midreset ferr", 32'(o_FrameError),          32'd0);
        check("midreset miso", 32'(o_SpiMiso),             32'd0);
        wait_clk(2);
        i_SpiChipSelect_n = 1'b1;
        wait_clk(2);
        i_Reset_n = 1'b1;
        wait_clk(12);
        check("midreset no write", 32'(got_q.size()), 32'd0);
        check("midreset no ferr",  32'(fe_count - fe0), 32'd0);
        fb[0] = 8'hC2; fb[1] = 8'h03; fb[2] = 8'h04;
        run_checked("after reset", 3, 0, 1'b0);

        // Random frames against the reference model.
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(0, 6);
            tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            cs_last = (tail == 0 && n > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
            run_checked($sformatf("rand%0d", r), n, tail, cs_last);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
